flag_branch_unit: RTL
=====================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface. Captures the N/Z/V flags produced by the 16-bit saturating add/sub and the other flag-setting ALU ops, using per-opcode update masks.
- Resolves 3-bit branch condition codes against those flags and returns a registered taken/next-PC result to fetch.
- Sits between the execute stage (flag producer) and PC-select logic (branch consumer).

Parameters:
- DATA_W, 16, width of PC / branch target / PC+2.
- OP_W, 4, width of ALU opcode used to select the flag update mask.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flag_we_i  in  1  ALU result valid this cycle; flags are updated per mask.
- alu_op_i  in  OP_W  opcode of the flag-producing instruction.
- n_i, z_i, v_i  in  1 each  flags from ALU (V = saturation/overflow occurred).
- br_valid_i  in  1  branch request valid.
- br_ready_o  out  1  unit accepts a request this cycle.
- br_cond_i  in  3  condition code.
- br_target_i  in  DATA_W  branch target address.
- pc_plus2_i  in  DATA_W  fall-through address.
- stall_i  in  1  downstream cannot take a result; hold outputs.
- flush_i  in  1  kill the in-flight result.
- br_out_valid_o  out  1  result valid.
- br_taken_o  out  1  condition true.
- next_pc_o  out  DATA_W  br_target_i if taken, else pc_plus2_i.
- flags_o  out  3  architectural {N,Z,V}.

Behaviour:
- Reset (async, rst_n=0):
  - flags_o=3'b000, br_out_valid_o=0, br_taken_o=0, next_pc_o=0.
  - br_ready_o follows ~stall_i combinationally, independent of reset.
- Flag update masks (on rising edge when flag_we_i=1):
  - ADD 4'b0000, SUB 4'b0001: write N, Z, V.
  - XOR 4'b0010, SLL 4'b0100, SRA 4'b0101, ROR 4'b0110: write Z only.
  - All other opcodes: no flag change.
  - Unmasked flags hold their value.
  - Flags update regardless of stall_i and flush_i.
- Condition codes, evaluated on effective flags:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or N=0.
  - 101 LTE: N=1 or Z=1.
  - 110 OVF: V=1.
  - 111 UNCOND: always taken.
- Handshake:
  - br_ready_o = ~stall_i.
  - A request is accepted when br_valid_i and br_ready_o are both 1.
  - Result is registered with latency 1: valid/taken/next_pc appear the cycle after acceptance.
- Output register priority (highest first):
  - flush_i: br_out_valid_o<=0, taken/next_pc hold.
  - stall_i: all outputs hold.
  - accept: load the new result.
  - otherwise: br_out_valid_o<=0.
- Boundary cases:
  - Simultaneous flag write and branch accept: see Optional Feature.
  - Flush and accept in the same cycle: the request is dropped, output valid=0.
  - Stall while a result is valid: the result persists unchanged until stall_i drops.
  - Back-to-back accepts: one result per cycle.
  - Reset mid-operation clears both the pending result and the flags immediately.
- Width rule: next_pc_o is a pure select, no arithmetic; addresses wrap naturally at DATA_W.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - Effective flags = masked merge of the incoming {n_i,z_i,v_i} into flags_o when flag_we_i=1 in the same cycle.
  - A branch immediately following ADD/SUB resolves without a bubble.
- Undefined:
  - Effective flags = flags_o register only.
  - Producer must insert one bubble between a flag-setting op and a dependent branch.

Decomposition:
- Package flag_pkg holds:
  - Opcode constants OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR.
  - Condition-code constants CC_NE … CC_UNCOND.
  - Flag bit indices FLAG_N=2, FLAG_Z=1, FLAG_V=0.
  - Function or typedef for the 3-bit update mask.
- One natural sub-module, cond_eval: combinational (flags, cond) -> taken.

Test Plan:
- Reset mid-run: rst_n low with flags=3'b111, valid=1 -> flags_o=000, br_out_valid_o=0, br_taken_o=0, next_pc_o=0 immediately.
- ADD 20000+10000 flags (N=0,Z=0,V=0), then cond=010 GT, target=16'h0040, pc+2=16'h0012 -> next cycle br_taken_o=1, next_pc_o=16'h0040.
- ADD saturating 32767+100 (V=1), then XOR with Z=1 -> flags_o=3'b011 (V retained). Cond 110 OVF -> taken; cond 000 NE -> not taken, next_pc_o=pc+2.
- stall_i=1 for 3 cycles with valid result -> outputs stable, br_ready_o=0, new request not accepted. Release -> pending request accepted, result next cycle.
- flush_i and accept in the same cycle -> br_out_valid_o=0 next cycle. Flags still update from a concurrent flag_we_i.
- SUB -32767-1234 (N=1, V=1) with a branch cond=011 LT in the same cycle:
  - FLAG_BYPASS_EN defined: taken.
  - Undefined, prior flags 000: not taken.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: opcodes, condition codes, flag bit
// positions and the per-opcode flag update mask.
package flag_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVF    = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef logic [2:0] flag_mask_t;

  // Arithmetic ops own all three flags; logic/shift ops only report zero.
  function automatic flag_mask_t upd_mask(input logic [3:0] op);
    flag_mask_t m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Execute/fetch-side bundle for the flag/branch unit. The master drives ALU flags
// and branch requests, and the slave (the unit) returns the resolved branch.
interface flag_branch_unit_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
);
  logic              flag_we_i;
  logic [OP_W-1:0]   alu_op_i;
  logic              n_i;
  logic              z_i;
  logic              v_i;
  logic              br_valid_i;
  logic              br_ready_o;
  logic [2:0]        br_cond_i;
  logic [DATA_W-1:0] br_target_i;
  logic [DATA_W-1:0] pc_plus2_i;
  logic              stall_i;
  logic              flush_i;
  logic              br_out_valid_o;
  logic              br_taken_o;
  logic [DATA_W-1:0] next_pc_o;
  logic [2:0]        flags_o;

  modport master (
    output flag_we_i, alu_op_i, n_i, z_i, v_i,
    output br_valid_i, br_cond_i, br_target_i, pc_plus2_i, stall_i, flush_i,
    input  br_ready_o, br_out_valid_o, br_taken_o, next_pc_o, flags_o
  );

  modport slave (
    input  flag_we_i, alu_op_i, n_i, z_i, v_i,
    input  br_valid_i, br_cond_i, br_target_i, pc_plus2_i, stall_i, flush_i,
    output br_ready_o, br_out_valid_o, br_taken_o, next_pc_o, flags_o
  );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition resolver: {N,Z,V} flags and a 3-bit condition
// code in, taken out.
module cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  logic w_n, w_z, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      CC_NE:     o_taken = ~w_z;
      CC_EQ:     o_taken = w_z;
      CC_GT:     o_taken = ~w_z & ~w_n;
      CC_LT:     o_taken = w_n;
      CC_GTE:    o_taken = w_z | ~w_n;
      CC_LTE:    o_taken = w_n | w_z;
      CC_OVF:    o_taken = w_v;
      CC_UNCOND: o_taken = 1'b1;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register plus registered branch resolution (latency 1).
// Define FLAG_BYPASS_EN to resolve branches on same-cycle ALU flags.
module flag_branch_unit
  import flag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  flag_branch_unit_if.slave bus
);

  logic [OP_W-1:0]   w_op;
  flag_mask_t        w_mask;
  logic [2:0]        w_flags_in;
  logic [2:0]        w_flags_nxt;
  logic [2:0]        w_flags_eff;
  logic              w_taken;
  logic              w_accept;

  logic [2:0]        r_flags;
  logic              r_out_valid;
  logic              r_taken;
  logic [DATA_W-1:0] r_next_pc;

  assign w_op        = bus.alu_op_i;
  assign w_mask      = bus.flag_we_i ? upd_mask(4'(w_op)) : '0;
  assign w_flags_in  = {bus.n_i, bus.z_i, bus.v_i};
  assign w_flags_nxt = (r_flags & ~w_mask) | (w_flags_in & w_mask);

`ifdef FLAG_BYPASS_EN
  assign w_flags_eff = w_flags_nxt;
`else
  assign w_flags_eff = r_flags;
`endif

  cond_eval u_cond_eval (
    .i_flags (w_flags_eff),
    .i_cond  (bus.br_cond_i),
    .o_taken (w_taken)
  );

  assign w_accept = bus.br_valid_i & ~bus.stall_i;

  // Flags track the ALU even while the branch path is stalled or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flags <= '0;
    else        r_flags <= w_flags_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_next_pc   <= '0;
    end else if (bus.flush_i) begin
      r_out_valid <= 1'b0;
    end else if (bus.stall_i) begin
      r_out_valid <= r_out_valid;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_taken     <= w_taken;
      r_next_pc   <= w_taken ? bus.br_target_i : bus.pc_plus2_i;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.br_ready_o     = ~bus.stall_i;
  assign bus.br_out_valid_o = r_out_valid;
  assign bus.br_taken_o     = r_taken;
  assign bus.next_pc_o      = r_next_pc;
  assign bus.flags_o        = r_flags;

endmodule
